// File: rtl/cnn_conv_engine.sv
// Fixed-point tiled convolution engine: Tm x Tn channel tile per cycle,
// one output pixel (Tm lanes) emitted per valid/ready beat.
module cnn_conv_engine #(
  parameter int N_p    = 4,
  parameter int M_p    = 4,
  parameter int K_p    = 2,
  parameter int R_p    = 16,
  parameter int C_p    = 16,
  parameter int S_p    = 1,
  parameter int Tn_p   = 2,
  parameter int Tm_p   = 2,
  parameter int DW_p   = 16,
  parameter int FRAC_p = 8,
  localparam int NT  = N_p / Tn_p,
  localparam int MT  = M_p / Tm_p,
  localparam int RO  = (R_p - K_p) / S_p + 1,
  localparam int CO  = (C_p - K_p) / S_p + 1,
  localparam int FAW = (NT*R_p*C_p > 1) ? $clog2(NT*R_p*C_p) : 1,
  localparam int WAW = (MT*NT*K_p*K_p > 1) ? $clog2(MT*NT*K_p*K_p) : 1,
  localparam int CHW = (MT > 1) ? $clog2(MT) : 1,
  localparam int ROW = (RO > 1) ? $clog2(RO) : 1,
  localparam int COW = (CO > 1) ? $clog2(CO) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      relu_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fm_rd_o,
  output logic [FAW-1:0]            fm_addr_o,
  input  logic [Tn_p*DW_p-1:0]      fm_data_i,
  output logic                      wt_rd_o,
  output logic [WAW-1:0]            wt_addr_o,
  input  logic [Tm_p*Tn_p*DW_p-1:0] wt_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [Tm_p*DW_p-1:0]      out_data_o,
  output logic [CHW-1:0]            out_ch_o,
  output logic [ROW-1:0]            out_row_o,
  output logic [COW-1:0]            out_col_o
);

  localparam int AW  = 2*DW_p + $clog2(N_p*K_p*K_p);
  localparam int TIW = (NT > 1) ? $clog2(NT) : 1;
  localparam int KW  = (K_p > 1) ? $clog2(K_p) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [AW-1:0] SMAX = AW'(2**(DW_p-1) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  logic [2:0]     st_q, st_d;
  logic           relu_q, relu_d;
  logic           pend_q, pend_d;
  logic [TIW-1:0] ti_q, ti_d;
  logic [KW-1:0]  i_q, i_d;
  logic [KW-1:0]  j_q, j_d;
  logic [CHW-1:0] to_q, to_d;
  logic [ROW-1:0] orow_q, orow_d;
  logic [COW-1:0] ocol_q, ocol_d;
  logic signed [AW-1:0] acc_q [Tm_p];
  logic signed [AW-1:0] acc_d [Tm_p];

  logic last_rd, last_px;
  logic signed [DW_p-1:0]   fa, wb;
  logic signed [2*DW_p-1:0] prod;

  assign last_rd = (j_q == KW'(K_p-1)) && (i_q == KW'(K_p-1)) &&
                   (ti_q == TIW'(NT-1));
  assign last_px = (ocol_q == COW'(CO-1)) && (orow_q == ROW'(RO-1)) &&
                   (to_q == CHW'(MT-1));

  always_comb begin
    st_d   = st_q;
    relu_d = relu_q;
    pend_d = (st_q == S_FETCH);
    ti_d   = ti_q;
    i_d    = i_q;
    j_d    = j_q;
    to_d   = to_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    fa     = '0;
    wb     = '0;
    prod   = '0;
    for (int tm = 0; tm < Tm_p; tm++) begin
      acc_d[tm] = acc_q[tm];
      if (pend_q) begin
        for (int tn = 0; tn < Tn_p; tn++) begin
          fa   = fm_data_i[tn*DW_p +: DW_p];
          wb   = wt_data_i[(tm*Tn_p+tn)*DW_p +: DW_p];
          prod = fa * wb;
          acc_d[tm] = acc_d[tm] + AW'(prod);
        end
      end
    end
    unique case (st_q)
      S_IDLE: begin
        if (start_i) begin
          st_d   = S_FETCH;
          relu_d = relu_i;
          for (int tm = 0; tm < Tm_p; tm++) acc_d[tm] = '0;
        end
      end
      S_FETCH: begin
        // reduction counters wrap to zero on the last read of the pixel
        if (j_q == KW'(K_p-1)) begin
          j_d = '0;
          if (i_q == KW'(K_p-1)) begin
            i_d  = '0;
            ti_d = (ti_q == TIW'(NT-1)) ? '0 : ti_q + TIW'(1);
          end else begin
            i_d = i_q + KW'(1);
          end
        end else begin
          j_d = j_q + KW'(1);
        end
        if (last_rd) st_d = S_DRAIN;
      end
      S_DRAIN: st_d = S_EMIT;
      S_EMIT: begin
        if (out_ready_i) begin
          if (ocol_q == COW'(CO-1)) begin
            ocol_d = '0;
            if (orow_q == ROW'(RO-1)) begin
              orow_d = '0;
              to_d   = (to_q == CHW'(MT-1)) ? '0 : to_q + CHW'(1);
            end else begin
              orow_d = orow_q + ROW'(1);
            end
          end else begin
            ocol_d = ocol_q + COW'(1);
          end
          if (last_px) begin
            st_d = S_DONE;
          end else begin
            st_d = S_FETCH;
            for (int tm = 0; tm < Tm_p; tm++) acc_d[tm] = '0;
          end
        end
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      st_q   <= S_IDLE;
      relu_q <= 1'b0;
      pend_q <= 1'b0;
      ti_q   <= '0;
      i_q    <= '0;
      j_q    <= '0;
      to_q   <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      for (int tm = 0; tm < Tm_p; tm++) acc_q[tm] <= '0;
    end else begin
      st_q   <= st_d;
      relu_q <= relu_d;
      pend_q <= pend_d;
      ti_q   <= ti_d;
      i_q    <= i_d;
      j_q    <= j_d;
      to_q   <= to_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      for (int tm = 0; tm < Tm_p; tm++) acc_q[tm] <= acc_d[tm];
    end
  end

  assign busy_o      = (st_q != S_IDLE);
  assign done_o      = (st_q == S_DONE);
  assign fm_rd_o     = (st_q == S_FETCH);
  assign wt_rd_o     = (st_q == S_FETCH);
  assign out_valid_o = (st_q == S_EMIT);
  assign out_ch_o    = to_q;
  assign out_row_o   = orow_q;
  assign out_col_o   = ocol_q;

  assign fm_addr_o = FAW'(((int'(ti_q)*R_p + int'(orow_q)*S_p + int'(i_q))
                     * C_p) + int'(ocol_q)*S_p + int'(j_q));
  assign wt_addr_o = WAW'(((int'(to_q)*NT + int'(ti_q))*K_p + int'(i_q))
                     * K_p + int'(j_q));

  logic signed [AW-1:0] sh;
  logic [DW_p-1:0]      ln;

  // floor shift, clamp to DW_p, then optional ReLU
  always_comb begin
    sh         = '0;
    ln         = '0;
    out_data_o = '0;
    for (int tm = 0; tm < Tm_p; tm++) begin
      sh = acc_q[tm] >>> FRAC_p;
      if (sh > SMAX)      ln = SMAX[DW_p-1:0];
      else if (sh < SMIN) ln = SMIN[DW_p-1:0];
      else                ln = sh[DW_p-1:0];
      if (relu_q && ln[DW_p-1]) ln = '0;
      out_data_o[tm*DW_p +: DW_p] = ln;
    end
  end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Bench for cnn_conv_engine: table vectors, stall/reset sequences,
// and randomized data checked against a direct convolution model.
module tb_cnn_conv_engine;

  localparam int N = 4, M = 4, K = 2, R = 16, C = 16, TN = 2, TM = 2;
  localparam int S = 1, RO = 15, CO = 15, P = 8;
  localparam int BEATS = 2 * RO * CO;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, relu = 1'b0, out_ready = 1'b1;
  logic        busy, done, fm_rd, wt_rd, out_valid;
  logic [8:0]  fm_addr;
  logic [3:0]  wt_addr;
  logic [31:0] fm_data = '0;
  logic [63:0] wt_data = '0;
  logic [31:0] out_data;
  logic [0:0]  out_ch;
  logic [3:0]  out_row, out_col;

  logic        start2 = 1'b0;
  logic        busy2, done2, fm_rd2, wt_rd2, out_valid2;
  logic [8:0]  fm_addr2;
  logic [3:0]  wt_addr2;
  logic [31:0] fm_data2 = '0;
  logic [63:0] wt_data2 = '0;
  logic [31:0] out_data2;
  logic [0:0]  out_ch2;
  logic [2:0]  out_row2, out_col2;

  cnn_conv_engine dut (
    .clk_i(clk), .reset_i(rst_n), .start_i(start), .relu_i(relu),
    .busy_o(busy), .done_o(done),
    .fm_rd_o(fm_rd), .fm_addr_o(fm_addr), .fm_data_i(fm_data),
    .wt_rd_o(wt_rd), .wt_addr_o(wt_addr), .wt_data_i(wt_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ch_o(out_ch),
    .out_row_o(out_row), .out_col_o(out_col)
  );

  cnn_conv_engine #(.S_p(2)) dut2 (
    .clk_i(clk), .reset_i(rst_n), .start_i(start2), .relu_i(1'b0),
    .busy_o(busy2), .done_o(done2),
    .fm_rd_o(fm_rd2), .fm_addr_o(fm_addr2), .fm_data_i(fm_data2),
    .wt_rd_o(wt_rd2), .wt_addr_o(wt_addr2), .wt_data_i(wt_data2),
    .out_valid_o(out_valid2), .out_ready_i(1'b1),
    .out_data_o(out_data2), .out_ch_o(out_ch2),
    .out_row_o(out_row2), .out_col_o(out_col2)
  );

  always #5 clk = ~clk;

  logic [31:0] fm_mem [512];
  logic [63:0] wt_mem [16];

  always @(posedge clk) begin
    fm_data  <= fm_mem[fm_addr];
    wt_data  <= wt_mem[wt_addr];
    fm_data2 <= fm_mem[fm_addr2];
    wt_data2 <= wt_mem[wt_addr2];
  end

  typedef struct {
    logic [0:0]  ch;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [15:0] fmv;
    logic [15:0] wv;
    logic        rl;
    int          bp;
    logic [15:0] expv;
  } vec_t;

  beat_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0;
  int nbeats, done_cnt, done_cyc, first_rd;
  int nbeats2, nrd2;
  int bp_mode = 0;
  bit stall_done, use_const, s2_on;
  logic [15:0] constv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_lane(input int to, input int tm,
      input int orow, input int ocol, input logic rl);
    longint acc = 0;
    longint v;
    logic [31:0] fw;
    logic [63:0] ww;
    for (int n = 0; n < N; n++)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) begin
          fw  = fm_mem[((n/TN)*R + orow*S + i)*C + ocol*S + j];
          ww  = wt_mem[(to*(N/TN) + n/TN)*K*K + i*K + j];
          acc += longint'(shortint'(fw[(n%TN)*16 +: 16])) *
                 longint'(shortint'(ww[(tm*TN + n%TN)*16 +: 16]));
        end
    v = acc >>> 8;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    if (rl && v < 0) v = 0;
    return 16'(v);
  endfunction

  task automatic build_exp(input logic rl);
    beat_t b;
    exp_q.delete();
    for (int to = 0; to < M/TM; to++)
      for (int r = 0; r < RO; r++)
        for (int c = 0; c < CO; c++) begin
          b.ch   = 1'(to);
          b.row  = 4'(r);
          b.col  = 4'(c);
          b.data = {ref_lane(to, 1, r, c, rl), ref_lane(to, 0, r, c, rl)};
          exp_q.push_back(b);
        end
  endtask

  function automatic logic [63:0] all_outs();
    return {5'b0, busy, done, fm_rd, wt_rd, out_valid, fm_addr, wt_addr,
            out_data, out_ch, out_row, out_col};
  endfunction

  // scoreboard / event monitor, sampled mid-cycle
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fm_rd && first_rd < 0) first_rd = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (out_valid && out_ready) begin
          nbeats++;
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(nbeats), 64'(BEATS));
          end else begin
            e = exp_q.pop_front();
            chk("beat", {out_ch, out_row, out_col, out_data},
                {e.ch, e.row, e.col, e.data});
          end
          if (use_const) chk("lane_const", out_data, {constv, constv});
        end
        if (s2_on && out_valid2) begin
          nbeats2++;
          chk("s2_lane", out_data2, 32'h1000_1000);
        end
        if (s2_on && fm_rd2) begin
          if (nrd2 == 9*P) chk("s2_px11_addr", fm_addr2, 64'd34);
          nrd2++;
        end
      end
    end
  end

  // consumer ready: always, one 10-cycle stall at beat 3, or random
  initial begin
    logic [63:0] snap;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 2) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else if (bp_mode == 1 && !stall_done && out_valid && nbeats == 3) begin
        snap = {out_ch, out_row, out_col, out_data};
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("stall_hold", {out_ch, out_row, out_col, out_data}, snap);
          chk("stall_no_rd", {fm_rd, out_valid}, 2'b01);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        stall_done = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic run_conv(input logic rl, input int bp, input bit mid_start);
    int n;
    build_exp(rl);
    nbeats = 0;
    done_cnt = 0;
    first_rd = -1;
    stall_done = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    relu = rl;
    start2 = s2_on;
    @(posedge clk);
    #1;
    start = 1'b0;
    start2 = 1'b0;
    relu = ~rl;
    bp_mode = bp;
    chk("first_rd_next_cycle", {busy, fm_rd, wt_rd}, 3'b111);
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      start = mid_start && (n == 100);
    end
    start = 1'b0;
    bp_mode = 0;
    chk("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("beat_count", 64'(nbeats), 64'(BEATS));
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_after", {busy, out_valid}, 2'b00);
  endtask

  task automatic fill_const(input logic [15:0] f, input logic [15:0] w);
    for (int a = 0; a < 512; a++) fm_mem[a] = {f, f};
    for (int a = 0; a < 16; a++) wt_mem[a] = {w, w, w, w};
  endtask

  vec_t vt[7];

  initial begin
    int n;
    vt[0] = '{16'h0100, 16'h0100, 1'b0, 0, 16'h1000};
    vt[1] = '{16'h0100, 16'h0100, 1'b0, 1, 16'h1000};
    vt[2] = '{16'h0100, 16'hFF00, 1'b0, 0, 16'hF000};
    vt[3] = '{16'h0100, 16'hFF00, 1'b1, 0, 16'h0000};
    vt[4] = '{16'h7FFF, 16'h7FFF, 1'b0, 0, 16'h7FFF};
    vt[5] = '{16'h8000, 16'h7FFF, 1'b0, 0, 16'h8000};
    vt[6] = '{16'h8000, 16'h7FFF, 1'b1, 0, 16'h0000};
    fill_const(16'h0100, 16'h0100);
    s2_on = 1'b0;
    use_const = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      fill_const(vt[k].fmv, vt[k].wv);
      use_const = 1'b1;
      constv = vt[k].expv;
      s2_on = (k == 0);
      nbeats2 = 0;
      nrd2 = 0;
      run_conv(vt[k].rl, vt[k].bp, k == 2);
      if (k == 0) begin
        // done lands in the 4501st cycle counting the first read as 1
        chk("done_latency", 64'(done_cyc - first_rd), 64'(BEATS*(P+2)));
        chk("s2_beats", 64'(nbeats2), 64'd128);
        chk("s2_idle", 64'(busy2), 64'd0);
      end
      s2_on = 1'b0;
    end

    // reset asserted in the middle of a FETCH
    fill_const(16'h0100, 16'h0100);
    constv = 16'h1000;
    build_exp(1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    relu = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    chk("pre_reset_fetch", {busy, fm_rd}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_conv(1'b0, 0, 1'b1);
    chk("done_latency_rerun", 64'(done_cyc - first_rd), 64'(BEATS*(P+2)));

    // randomized data with random backpressure
    use_const = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 512; a++)
        fm_mem[a] = {16'($urandom_range(0, 1023) - 512),
                     16'($urandom_range(0, 1023) - 512)};
      for (int a = 0; a < 16; a++)
        for (int l = 0; l < 4; l++)
          wt_mem[a][l*16 +: 16] = 16'($urandom_range(0, 1023) - 512);
      run_conv(r == 1, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
